// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Start/done handshake and operand/result bundle for the
//               bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor (diff = a - b), one
//               full-subtractor cell evaluated per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    logic             accept;
    logic             last_bit;
    logic             bit_d;
    logic             bit_br;

    // A start is honoured only when no operation is in flight (IDLE or DONE).
    assign accept   = bus.start && (state != RUN);
    assign last_bit = (state == RUN) && (cnt == LAST_CNT);

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign bit_d  = sa[0] ^ sb[0] ^ br;
    assign bit_br = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE can chain straight into a new RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand shifting, borrow chain and result capture on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            sa    <= bus.a;
            sb    <= bus.b;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
        end else if (state == RUN) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            res <= {bit_d, res[WIDTH-1:1]};
            br  <= bit_br;
            cnt <= cnt + 1'b1;
            if (last_bit) begin
                // The incoming bit is the result MSB, so use it directly.
                diff_q   <= {bit_d, res[WIDTH-1:1]};
                borrow_q <= bit_br;
                ovf_q    <= (a_msb != b_msb) && (bit_d != a_msb);
            end
        end
    end

    // Status flags follow the state register directly.
    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_subtractor_if #(.WIDTH(W)) bus_if ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] m_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        return x - y;
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'($signed(x)) - int'($signed(y));
        return (r < -(2 ** (W - 1))) || (r > (2 ** (W - 1)) - 1);
    endfunction

    int           rem      = 0;   // bit-cycles still to run; 0 = not busy
    logic         m_done   = 1'b0;
    logic [W-1:0] m_diff   = '0;
    logic         m_borrow = 1'b0;
    logic         m_ovf_o  = 1'b0;
    logic [W-1:0] p_diff   = '0;
    logic         p_borrow = 1'b0;
    logic         p_ovf    = 1'b0;

    // Timing model: WIDTH cycles after acceptance the pending result is published.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= 0;
            m_done   <= 1'b0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_ovf_o  <= 1'b0;
        end else begin
            if (rem == 1) begin
                m_done   <= 1'b1;
                m_diff   <= p_diff;
                m_borrow <= p_borrow;
                m_ovf_o  <= p_ovf;
            end else begin
                m_done <= 1'b0;
            end
            if (rem != 0) begin
                rem <= rem - 1;
            end else if (bus_if.start) begin
                rem      <= W;
                p_diff   <= m_sub(bus_if.a, bus_if.b);
                p_borrow <= (bus_if.a < bus_if.b);
                p_ovf    <= m_ovf(bus_if.a, bus_if.b);
            end
        end
    end

    // Per-cycle comparison against the model.
    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   {31'd0, bus_if.busy},   {31'd0, (rem != 0)});
            check("done",   {31'd0, bus_if.done},   {31'd0, m_done});
            check("diff",   {24'd0, bus_if.diff},   {24'd0, m_diff});
            check("borrow", {31'd0, bus_if.borrow}, {31'd0, m_borrow});
            check("ovf",    {31'd0, bus_if.ovf},    {31'd0, m_ovf_o});
        end
    end

    int done_pulses = 0;
    int cyc = 0;
    always @(negedge clk) if (bus_if.done) done_pulses <= done_pulses + 1;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (bus_if.done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        bit ok;
        @(negedge clk);
        bus_if.a     = x;
        bus_if.b     = y;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.a     = ~x;          // operands may change after acceptance
        bus_if.b     = x ^ y;
        wait_done(tag, ok);
        if (ok) begin
            check({tag, "_diff"},   {24'd0, bus_if.diff},   {24'd0, ed});
            check({tag, "_borrow"}, {31'd0, bus_if.borrow}, {31'd0, eb});
            check({tag, "_ovf"},    {31'd0, bus_if.ovf},    {31'd0, eo});
        end
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int p0;
        int stamps[3];
        int n;

        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_done", {31'd0, bus_if.done}, 32'd0);
        check("rst_diff", {24'd0, bus_if.diff}, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_op("op_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("op_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("op_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("op_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("op_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Start during RUN must be ignored.
        p0 = done_pulses;
        @(negedge clk);
        bus_if.a = 8'h10; bus_if.b = 8'h01; bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (2) @(negedge clk);
        bus_if.a = 8'hFF; bus_if.b = 8'h00; bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done("ign", ok);
        if (ok) check("ign_diff", {24'd0, bus_if.diff}, 32'h0F);
        repeat (14) @(negedge clk);
        check("ign_pulses", done_pulses - p0, 32'd1);

        // Reset in the middle of RUN.
        @(negedge clk);
        bus_if.a = 8'h20; bus_if.b = 8'h10; bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus_if.done}, 32'd0);
        check("mid_rst_diff", {24'd0, bus_if.diff}, 32'd0);
        p0 = done_pulses;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        check("mid_rst_pulses", done_pulses - p0, 32'd0);
        run_op("op_09_04", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk);
        bus_if.a = 8'h0A; bus_if.b = 8'h01; bus_if.start = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (bus_if.done) begin
                stamps[n] = cyc;
                check("b2b_diff", {24'd0, bus_if.diff}, 32'h09);
                n = n + 1;
            end
        end
        bus_if.start = 1'b0;
        check("b2b_count", n, 32'd3);
        if (n == 3) begin
            check("b2b_gap1", stamps[1] - stamps[0], 32'd9);
            check("b2b_gap2", stamps[2] - stamps[1], 32'd9);
        end
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
